// File: rtl/arcade_ctrl_pkg.sv
// Shared indices, state encodings and the direction-cleaning helper for the arcade control hub.
package arcade_ctrl_pkg;

  localparam int IDX_UP    = 0;
  localparam int IDX_DOWN  = 1;
  localparam int IDX_LEFT  = 2;
  localparam int IDX_RIGHT = 3;
  localparam int IDX_BTN0  = 4;

  typedef enum logic [1:0] {C_IDLE, C_HOLD, C_WAIT_REL} coin_st_e;
  typedef enum logic       {R_IDLE, R_PULSE}            rst_st_e;

  // Opposing directions cancel each other so the core never sees an impossible stick position.
  function automatic logic [3:0] socd_clean(input logic [3:0] dir);
    logic [3:0] res;
    res = dir;
    if (dir[IDX_UP] && dir[IDX_DOWN]) begin
      res[IDX_UP]   = 1'b0;
      res[IDX_DOWN] = 1'b0;
    end
    if (dir[IDX_LEFT] && dir[IDX_RIGHT]) begin
      res[IDX_LEFT]  = 1'b0;
      res[IDX_RIGHT] = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/arcade_ctrl_if.sv
// Keyboard/DB9 request bundle and the merged control outputs toward the arcade core.
interface arcade_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int BTN_W       = 3
);
  localparam int W = 4 + BTN_W;

  logic [NUM_PLAYERS*W-1:0] kbd_joy_i;
  logic [NUM_PLAYERS*W-1:0] db9_n_i;
  logic [NUM_PLAYERS-1:0]   kbd_coin_i;
  logic [NUM_PLAYERS-1:0]   kbd_start_i;
  logic                     kbd_scandbl_i;
  logic                     kbd_scanl_i;
  logic                     kbd_reset_i;
  logic [NUM_PLAYERS-1:0]   kbd_autofire_i;

  logic [NUM_PLAYERS*W-1:0] joy_o;
  logic [NUM_PLAYERS-1:0]   coin_o;
  logic [NUM_PLAYERS-1:0]   start_o;
  logic                     scandbl_dis_o;
  logic [1:0]               scanlines_o;
  logic                     core_reset_o;

  modport master (
    output kbd_joy_i, db9_n_i, kbd_coin_i, kbd_start_i, kbd_scandbl_i,
           kbd_scanl_i, kbd_reset_i, kbd_autofire_i,
    input  joy_o, coin_o, start_o, scandbl_dis_o, scanlines_o, core_reset_o
  );

  modport slave (
    input  kbd_joy_i, db9_n_i, kbd_coin_i, kbd_start_i, kbd_scandbl_i,
           kbd_scanl_i, kbd_reset_i, kbd_autofire_i,
    output joy_o, coin_o, start_o, scandbl_dis_o, scanlines_o, core_reset_o
  );

endinterface

// File: rtl/ctrl_debounce.sv
// Two-flop synchroniser plus per-bit debounce for active-low DB9 pins; output is active-high.
module ctrl_debounce #(
  parameter int WIDTH   = 1,
  parameter int DEB_CYC = 240000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] din_n,
  output logic [WIDTH-1:0] dout
);
  localparam int CW = $clog2(DEB_CYC + 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] accepted;
  logic [CW-1:0]    cnt [WIDTH];

  // Idle pins read high, so the synchroniser resets to released and nothing is accepted.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1    <= '1;
      sync2    <= '1;
      accepted <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= din_n;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (!sync2[i] != accepted[i]) begin
          if (cnt[i] == CW'(DEB_CYC - 1)) begin
            accepted[i] <= !sync2[i];
            cnt[i]      <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign dout = accepted;

endmodule

// File: rtl/arcade_ctrl_hub.sv
// Arcade control front-end: joystick merge, coin/start, video toggles and core reset pulse.
// Optional autofire is built only when AUTOFIRE_EN is defined.
module arcade_ctrl_hub
  import arcade_ctrl_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int BTN_W       = 3,
  parameter int DEB_CYC     = 240000,
  parameter int COIN_CYC    = 2400000,
  parameter int RST_CYC     = 65536,
  parameter int SL_LEVELS   = 4,
  parameter int AF_HALF_CYC = 1200000
) (
  input  logic          clk_i,
  input  logic          reset_i,
  arcade_ctrl_if.slave  bus
);
  localparam int W   = 4 + BTN_W;
  localparam int PW  = NUM_PLAYERS * W;
  localparam int CCW = $clog2(COIN_CYC + 1);
  localparam int RCW = $clog2(RST_CYC + 1);
  localparam logic [1:0] SL_MAX = 2'(SL_LEVELS - 1);

  logic [PW-1:0] deb;
  logic [PW-1:0] raw;
  logic [PW-1:0] clean;
  logic [PW-1:0] joy_q;

  ctrl_debounce #(.WIDTH(PW), .DEB_CYC(DEB_CYC)) u_debounce (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .din_n   (bus.db9_n_i),
    .dout    (deb)
  );

  logic [NUM_PLAYERS-1:0] coin_q, coin_qq, start_q;
  logic scandbl_q, scandbl_qq, scanl_q, scanl_qq, rst_q, rst_qq;

  // Requests are plain levels; one register stage plus a delayed copy gives clean rising edges.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      coin_q     <= '0;
      coin_qq    <= '0;
      start_q    <= '0;
      scandbl_q  <= 1'b0;
      scandbl_qq <= 1'b0;
      scanl_q    <= 1'b0;
      scanl_qq   <= 1'b0;
      rst_q      <= 1'b0;
      rst_qq     <= 1'b0;
    end else begin
      coin_q     <= bus.kbd_coin_i;
      coin_qq    <= coin_q;
      start_q    <= bus.kbd_start_i;
      scandbl_q  <= bus.kbd_scandbl_i;
      scandbl_qq <= scandbl_q;
      scanl_q    <= bus.kbd_scanl_i;
      scanl_qq   <= scanl_q;
      rst_q      <= bus.kbd_reset_i;
      rst_qq     <= rst_q;
    end
  end

  logic [NUM_PLAYERS-1:0] coin_rise;
  logic scandbl_rise, scanl_rise, rst_rise;
  assign coin_rise    = coin_q & ~coin_qq;
  assign scandbl_rise = scandbl_q & ~scandbl_qq;
  assign scanl_rise   = scanl_q & ~scanl_qq;
  assign rst_rise     = rst_q & ~rst_qq;

  assign raw = bus.kbd_joy_i | deb;

`ifdef AUTOFIRE_EN
  localparam int AFW = $clog2(AF_HALF_CYC + 1);
  logic [NUM_PLAYERS-1:0] af_q, af_qq, af_on, af_phase;
  logic [AFW-1:0]         af_cnt [NUM_PLAYERS];

  // The phase restarts high whenever button 0 is released so every press begins with a shot.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      af_q     <= '0;
      af_qq    <= '0;
      af_on    <= '0;
      af_phase <= '1;
      for (int p = 0; p < NUM_PLAYERS; p++) af_cnt[p] <= '0;
    end else begin
      af_q  <= bus.kbd_autofire_i;
      af_qq <= af_q;
      af_on <= af_on ^ (af_q & ~af_qq);
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (!raw[p*W + IDX_BTN0]) begin
          af_phase[p] <= 1'b1;
          af_cnt[p]   <= '0;
        end else if (af_cnt[p] == AFW'(AF_HALF_CYC - 1)) begin
          af_phase[p] <= ~af_phase[p];
          af_cnt[p]   <= '0;
        end else begin
          af_cnt[p] <= af_cnt[p] + 1'b1;
        end
      end
    end
  end
`else
  logic unused_autofire;
  assign unused_autofire = ^{bus.kbd_autofire_i, AF_HALF_CYC[0]};
`endif

  always_comb begin
    clean = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      clean[p*W +: 4]     = socd_clean(raw[p*W +: 4]);
      clean[p*W+4 +: BTN_W] = raw[p*W+4 +: BTN_W];
`ifdef AUTOFIRE_EN
      clean[p*W + IDX_BTN0] = raw[p*W + IDX_BTN0] & (~af_on[p] | af_phase[p]);
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) joy_q <= '0;
    else         joy_q <= clean;
  end

  coin_st_e               coin_st [NUM_PLAYERS];
  coin_st_e               coin_nx [NUM_PLAYERS];
  logic [CCW-1:0]         coin_cnt [NUM_PLAYERS];
  logic [CCW-1:0]         coin_cnt_nx [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] coin_out;

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (reset_i) begin
        coin_st[p]  <= C_IDLE;
        coin_cnt[p] <= '0;
      end else begin
        coin_st[p]  <= coin_nx[p];
        coin_cnt[p] <= coin_cnt_nx[p];
      end
    end
  end

  // A held key produces one pulse; the FSM waits for release before it can fire again.
  always_comb begin
    coin_out = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      coin_nx[p]     = coin_st[p];
      coin_cnt_nx[p] = coin_cnt[p];
      unique case (coin_st[p])
        C_IDLE: begin
          if (coin_rise[p]) begin
            coin_nx[p]     = C_HOLD;
            coin_cnt_nx[p] = '0;
          end
        end
        C_HOLD: begin
          coin_out[p] = 1'b1;
          if (coin_cnt[p] == CCW'(COIN_CYC - 1)) begin
            coin_nx[p]     = C_WAIT_REL;
            coin_cnt_nx[p] = '0;
          end else begin
            coin_cnt_nx[p] = coin_cnt[p] + 1'b1;
          end
        end
        C_WAIT_REL: begin
          if (!coin_q[p]) coin_nx[p] = C_IDLE;
        end
        default: coin_nx[p] = C_IDLE;
      endcase
    end
  end

  rst_st_e        rst_st, rst_nx;
  logic [RCW-1:0] rst_cnt, rst_cnt_nx;

  // Hub reset parks the FSM in PULSE so the core is held for a full pulse after power-up.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rst_st  <= R_PULSE;
      rst_cnt <= '0;
    end else begin
      rst_st  <= rst_nx;
      rst_cnt <= rst_cnt_nx;
    end
  end

  always_comb begin
    rst_nx     = rst_st;
    rst_cnt_nx = rst_cnt;
    unique case (rst_st)
      R_IDLE: begin
        if (rst_rise) begin
          rst_nx     = R_PULSE;
          rst_cnt_nx = '0;
        end
      end
      R_PULSE: begin
        if (rst_rise) begin
          rst_cnt_nx = '0;
        end else if (rst_cnt == RCW'(RST_CYC - 1)) begin
          rst_nx     = R_IDLE;
          rst_cnt_nx = '0;
        end else begin
          rst_cnt_nx = rst_cnt + 1'b1;
        end
      end
      default: rst_nx = R_IDLE;
    endcase
  end

  logic       scandbl_dis;
  logic [1:0] sl_level;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      scandbl_dis <= 1'b0;
      sl_level    <= '0;
    end else begin
      if (scandbl_rise) scandbl_dis <= ~scandbl_dis;
      if (scanl_rise)   sl_level    <= (sl_level == SL_MAX) ? 2'd0 : sl_level + 2'd1;
    end
  end

  assign bus.joy_o         = joy_q;
  assign bus.coin_o        = coin_out;
  assign bus.start_o       = start_q;
  assign bus.scandbl_dis_o = scandbl_dis;
  assign bus.scanlines_o   = scandbl_dis ? 2'd0 : sl_level;
  assign bus.core_reset_o  = (rst_st == R_PULSE);

endmodule

// File: tb/tb_arcade_ctrl_hub.sv
// Directed bench for arcade_ctrl_hub; the autofire expectations follow AUTOFIRE_EN.
module tb_arcade_ctrl_hub;
  localparam int P  = 2;
  localparam int BW = 3;
  localparam int W  = 4 + BW;
  localparam int PW = P * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  arcade_ctrl_if #(.NUM_PLAYERS(P), .BTN_W(BW)) bus ();

  arcade_ctrl_hub #(
    .NUM_PLAYERS (P),
    .BTN_W       (BW),
    .DEB_CYC     (4),
    .COIN_CYC    (8),
    .RST_CYC     (16),
    .SL_LEVELS   (4),
    .AF_HALF_CYC (3)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [PW-1:0] kbd;
    logic [PW-1:0] exp_joy;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [PW-1:0] kbd);
    bus.kbd_joy_i = kbd;
    @(negedge clk);
  endtask

  // which: 0 scanl, 1 scandbl, 2 both, 3 kbd reset, 4 autofire p0
  task automatic pulseReq(input int which);
    if (which == 0 || which == 2) bus.kbd_scanl_i = 1'b1;
    if (which == 1 || which == 2) bus.kbd_scandbl_i = 1'b1;
    if (which == 3) bus.kbd_reset_i = 1'b1;
    if (which == 4) bus.kbd_autofire_i = 2'b01;
    repeat (2) @(negedge clk);
    bus.kbd_scanl_i    = 1'b0;
    bus.kbd_scandbl_i  = 1'b0;
    bus.kbd_reset_i    = 1'b0;
    bus.kbd_autofire_i = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic measureCoin(input int cycles, input int release_at,
                             output int pulses, output int width, output int first, output int other);
    logic prev;
    prev = 1'b0; pulses = 0; width = 0; first = 0; other = 0;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      if (bus.coin_o[1]) width++;
      if (bus.coin_o[1] && !prev) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (bus.coin_o[0]) other++;
      prev = bus.coin_o[1];
      if (k == release_at) bus.kbd_coin_i = '0;
    end
  endtask

  initial begin
    int hi, first, last, seen, pulses, width, other;
    int sl_exp [5];

    vecs[0] = '{kbd: 14'h0000, exp_joy: 14'h0000};
    vecs[1] = '{kbd: 14'h0001, exp_joy: 14'h0001};
    vecs[2] = '{kbd: 14'h0003, exp_joy: 14'h0000};
    vecs[3] = '{kbd: 14'h000C, exp_joy: 14'h0000};
    vecs[4] = '{kbd: 14'h0015, exp_joy: 14'h0015};
    vecs[5] = '{kbd: 14'h0047, exp_joy: 14'h0044};
    vecs[6] = '{kbd: 14'h1580, exp_joy: 14'h1400};
    vecs[7] = '{kbd: 14'h3FFF, exp_joy: 14'h3870};
    vecs[8] = '{kbd: 14'h028A, exp_joy: 14'h028A};
    sl_exp = '{1, 2, 3, 0, 1};

    bus.kbd_joy_i      = '0;
    bus.db9_n_i        = '1;
    bus.kbd_coin_i     = '0;
    bus.kbd_start_i    = '0;
    bus.kbd_scandbl_i  = 1'b0;
    bus.kbd_scanl_i    = 1'b0;
    bus.kbd_reset_i    = 1'b0;
    bus.kbd_autofire_i = '0;
    bus.kbd_joy_i      = 14'h3FFF;
    bus.kbd_coin_i     = 2'b11;
    bus.kbd_start_i    = 2'b11;
    repeat (3) @(negedge clk);
    checkOutput("reset_joy", 32'(bus.joy_o), 0);
    checkOutput("reset_coin", 32'(bus.coin_o), 0);
    checkOutput("reset_start", 32'(bus.start_o), 0);
    checkOutput("reset_scandbl", 32'(bus.scandbl_dis_o), 0);
    checkOutput("reset_scanl", 32'(bus.scanlines_o), 0);
    checkOutput("reset_core", 32'(bus.core_reset_o), 1);
    bus.kbd_joy_i   = '0;
    bus.kbd_coin_i  = '0;
    bus.kbd_start_i = '0;

    hi = bus.core_reset_o ? 1 : 0;
    rst = 1'b0;
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      if (bus.core_reset_o) hi++;
    end
    checkOutput("core_reset_len", 32'(hi), 16);
    checkOutput("core_reset_done", 32'(bus.core_reset_o), 0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].kbd);
      checkOutput($sformatf("merge_vec%0d", i), 32'(bus.joy_o), 32'(vecs[i].exp_joy));
    end
    applyStimulus('0);

    bus.kbd_start_i = 2'b01;
    @(negedge clk);
    checkOutput("start_reg", 32'(bus.start_o), 1);
    bus.kbd_start_i = 2'b10;
    @(negedge clk);
    checkOutput("start_reg2", 32'(bus.start_o), 2);
    bus.kbd_start_i = '0;
    repeat (2) @(negedge clk);

    seen = 0;
    bus.db9_n_i[0] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (bus.joy_o[0]) seen++;
      if (k == 3) bus.db9_n_i[0] = 1'b1;
    end
    checkOutput("bounce_reject", 32'(seen), 0);

    first = 0;
    bus.db9_n_i[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.joy_o[0] && first == 0) first = k;
      if (k == 10) bus.db9_n_i[0] = 1'b1;
    end
    checkOutput("deb_latency", 32'(first), 7);
    repeat (10) @(negedge clk);
    checkOutput("deb_release", 32'(bus.joy_o[0]), 0);

    bus.kbd_joy_i[0] = 1'b1;
    bus.db9_n_i[1]   = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("socd_mixed", 32'(bus.joy_o[3:0]), 0);
    bus.db9_n_i[1] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) checkOutput("socd_hold", 32'(bus.joy_o[1:0]), 0);
      if (k == 7) checkOutput("socd_release", 32'(bus.joy_o[1:0]), 1);
    end
    bus.kbd_joy_i = '0;
    repeat (2) @(negedge clk);

    bus.kbd_coin_i = 2'b10;
    measureCoin(44, 40, pulses, width, first, other);
    checkOutput("coin1_pulses", 32'(pulses), 1);
    checkOutput("coin1_width", 32'(width), 8);
    checkOutput("coin1_start", 32'(first), 2);
    checkOutput("coin0_quiet", 32'(other), 0);
    bus.kbd_coin_i = 2'b10;
    measureCoin(16, 12, pulses, width, first, other);
    checkOutput("coin2_pulses", 32'(pulses), 1);
    checkOutput("coin2_width", 32'(width), 8);

    for (int i = 0; i < 5; i++) begin
      pulseReq(0);
      checkOutput($sformatf("scanl_step%0d", i), 32'(bus.scanlines_o), 32'(sl_exp[i]));
    end
    pulseReq(1);
    checkOutput("scandbl_on", 32'(bus.scandbl_dis_o), 1);
    checkOutput("scanl_masked", 32'(bus.scanlines_o), 0);
    pulseReq(0);
    checkOutput("scanl_masked2", 32'(bus.scanlines_o), 0);
    pulseReq(1);
    checkOutput("scandbl_off", 32'(bus.scandbl_dis_o), 0);
    checkOutput("scanl_kept", 32'(bus.scanlines_o), 2);
    pulseReq(2);
    checkOutput("both_dis", 32'(bus.scandbl_dis_o), 1);
    pulseReq(1);
    checkOutput("both_level", 32'(bus.scanlines_o), 3);

    hi = 0; first = 0; last = 0;
    bus.kbd_reset_i = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.core_reset_o) begin
        hi++;
        last = k;
        if (first == 0) first = k;
      end
      if (k == 2 || k == 12) bus.kbd_reset_i = 1'b0;
      if (k == 10) bus.kbd_reset_i = 1'b1;
    end
    checkOutput("kreset_first", 32'(first), 2);
    checkOutput("kreset_last", 32'(last), 27);
    checkOutput("kreset_len", 32'(hi), 26);
    checkOutput("kreset_keeps_dis", 32'(bus.scandbl_dis_o), 0);
    checkOutput("kreset_keeps_sl", 32'(bus.scanlines_o), 3);

`ifdef AUTOFIRE_EN
    pulseReq(4);
    bus.kbd_joy_i[4] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checkOutput($sformatf("autofire_c%0d", k), 32'(bus.joy_o[4]), (((k - 1) / 3) % 2 == 0) ? 1 : 0);
    end
`else
    pulseReq(4);
    bus.kbd_joy_i[4] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checkOutput($sformatf("btn0_c%0d", k), 32'(bus.joy_o[4]), 1);
    end
`endif
    bus.kbd_joy_i[4] = 1'b0;
    @(negedge clk);
    checkOutput("btn0_release", 32'(bus.joy_o[4]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
